sha256_job_arbiter: RTL and testbench
=====================================

Name: sha256_job_arbiter

Overview:
- Shares one simplified SHA-256 core among NUM_REQ requesters, for example several nonce workers in the bitcoin miner.
- Grants requesters round-robin and latches the granted requester's message/output addresses onto the core.
- Issues a one-cycle start, tracks the core's level-style done (high whenever the core is idle) through busy and back to idle, then returns a one-cycle ack to the owner.
- Reports the cycle count of the last job.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 4, cycles allowed for core_done to drop after a start pulse before the start is retried.
- CNT_W, 16, width of the job cycle counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester job request; level, held until ack
- req_message_addr  in  NUM_REQ*16  flattened; slice i = requester i message base address
- req_output_addr  in  NUM_REQ*16  flattened; slice i = requester i output base address
- grant  out  NUM_REQ  one-hot owner of the core; 0 when no job is active
- ack  out  NUM_REQ  one-cycle pulse on the owner's bit at job completion
- core_start  out  1  start pulse to the core
- core_message_addr  out  16  latched message address of the owner
- core_output_addr  out  16  latched output address of the owner
- core_done  in  1  core done; high while the core is idle
- busy  out  1  high in every state except IDLE
- last_cycles  out  CNT_W  cycles from start pulse to core_done re-rising, for the last completed job; saturates at all-ones
- retry_count  out  8  number of start retries since reset; saturating

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - grant, ack, core_start, busy, core_message_addr, core_output_addr, last_cycles, retry_count = 0.
  - last_grant pointer = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered. core_start and ack are single-cycle pulses.
- Arbitration: round-robin. Search starts at (last_grant+1) mod NUM_REQ and wraps to find the first set req bit. last_grant updates only in ACK.
- IDLE:
  - If req≠0 and core_done=1: set grant one-hot to the winner, latch its address slices onto core_message_addr/core_output_addr, go to LAUNCH.
  - If core_done=0 (core busy from a foreign source or not yet idle), stay in IDLE.
- LAUNCH: core_start=1 for exactly one cycle; clear the cycle counter and timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - Cycle counter increments every cycle.
  - If core_done=0, go to WAIT_DONE.
  - Else increment the timeout counter. When it reaches START_TIMEOUT, increment retry_count and go back to LAUNCH. grant and addresses are kept.
- WAIT_DONE:
  - Cycle counter increments.
  - When core_done=1: last_cycles ← counter+1 (saturating), go to ACK.
- ACK: ack[owner]=1 for one cycle, last_grant ← owner, grant ← 0, go to IDLE. busy drops the cycle after ACK.
- Minimum gap between consecutive jobs is one IDLE cycle.
- Requester rules:
  - Requester must deassert req in the cycle after it sees ack. If req is still high, it competes again at lowest priority.
  - Deasserting req while granted does not abort the job. The job completes and ack still pulses.
- Address inputs are sampled only in the IDLE→LAUNCH transition. Later changes have no effect on the running job.
- Counters: cycle counter saturates at 2^CNT_W-1 and does not wrap. retry_count saturates at 255.
- Simultaneous events:
  - New req bits arriving during a job are held off until IDLE.
  - core_done rising in the same cycle the counter saturates still completes normally.
- Reset mid-operation forces IDLE immediately: grant=0, no ack is issued for the aborted job. The core shares reset_n.

Test Plan:
- Single request: req=4'b0001, msg=16'h0000, out=16'h0100, with the real core. Expected: one core_start pulse; grant=0001 until ack; ack=0001 for one cycle; memory at 0x0100..0x0107 matches the reference SHA-256 of the 20-word message; last_cycles equals the measured start→done cycles.
- All four requesters assert simultaneously from reset, using a stub core with done low for 10 cycles. Expected: service order 0,1,2,3; four distinct acks; last_cycles=11 each; no overlapping grants.
- Fairness: requester 1 holds req high continuously and requester 3 asserts during job 1. Expected: order 1,3,1,3… with requester 1 never served twice in a row while 3 is pending.
- Start timeout: stub core ignores the first start and keeps done=1. Expected: second core_start exactly START_TIMEOUT+1 cycles after the first; retry_count=1; job then completes with a normal ack.
- Reset mid-job: assert reset_n=0 during WAIT_DONE. Expected: grant, ack, busy, core_start=0 in the same cycle; after release, requester 0 has priority and a fresh job completes.
- Address stability: change req_output_addr of the owner to 16'h0200 mid-job. Expected: core_output_addr stays at 16'h0100 until ack; hash is written at 0x0100.

Source files
------------

// File: rtl/sha256_job_arbiter.sv
//==============================================================================
// Module   : sha256_job_arbiter
// Purpose  : Round-robin arbiter sharing one SHA-256 core among NUM_REQ
//            requesters, with start retry and job cycle measurement.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module sha256_job_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*16-1:0] req_message_addr,
    input  logic [NUM_REQ*16-1:0] req_output_addr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  core_start,
    output logic [15:0]           core_message_addr,
    output logic [15:0]           core_output_addr,
    input  logic                  core_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      last_cycles,
    output logic [7:0]            retry_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] c_timeout_last = TO_W'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_ACK       = 3'd4
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [TO_W-1:0]    r_to;

    logic [IDX_W-1:0]   w_win;
    logic               w_found;
    logic [NUM_REQ-1:0] w_onehot;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Walk offsets from far to near so the requester nearest after r_last wins.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(r_last) + k) % NUM_REQ]) begin
                w_win   = IDX_W'((int'(r_last) + k) % NUM_REQ);
                w_found = 1'b1;
            end
        end
    end

    assign w_onehot  = NUM_REQ'(1) << w_win;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_last            <= IDX_W'(NUM_REQ - 1);
            r_owner           <= '0;
            r_cnt             <= '0;
            r_to              <= '0;
            grant             <= '0;
            ack               <= '0;
            core_start        <= 1'b0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
            busy              <= 1'b0;
            last_cycles       <= '0;
            retry_count       <= '0;
        end else begin
            core_start <= 1'b0;
            ack        <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && core_done) begin
                        grant             <= w_onehot;
                        r_owner           <= w_win;
                        core_message_addr <= req_message_addr[int'(w_win)*16 +: 16];
                        core_output_addr  <= req_output_addr[int'(w_win)*16 +: 16];
                        busy              <= 1'b1;
                        core_start        <= 1'b1;
                        r_state           <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_to    <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (!core_done) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to == c_timeout_last) begin
                        // Core never left idle: pulse start again, keeping grant and addresses.
                        r_to       <= '0;
                        core_start <= 1'b1;
                        r_state    <= S_LAUNCH;
                        if (retry_count != 8'hFF) begin
                            retry_count <= retry_count + 8'd1;
                        end
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    r_cnt <= w_cnt_inc;
                    if (core_done) begin
                        last_cycles <= w_cnt_inc;
                        ack         <= grant;
                        r_state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_last  <= r_owner;
                    grant   <= '0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_job_arbiter.sv
//==============================================================================
// Module   : tb_sha256_job_arbiter
// Purpose  : Self-checking bench for sha256_job_arbiter using a stub core.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_sha256_job_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*16-1:0]   maddr;
    logic [N*16-1:0]   oaddr;
    logic [N-1:0]      grant;
    logic [N-1:0]      ack;
    logic              core_start;
    logic [15:0]       core_message_addr;
    logic [15:0]       core_output_addr;
    logic              core_done;
    logic              busy;
    logic [CW-1:0]     last_cycles;
    logic [7:0]        retry_count;

    sha256_job_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TO),
        .CNT_W         (CW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .req_message_addr  (maddr),
        .req_output_addr   (oaddr),
        .grant             (grant),
        .ack               (ack),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done),
        .busy              (busy),
        .last_cycles       (last_cycles),
        .retry_count       (retry_count)
    );

    always #5 clk = ~clk;

    // Stub core: done drops for job_lat cycles after an accepted start.
    int stub_cnt    = 0;
    int stub_starts = 0;
    int ign_upto    = 0;
    int job_lat     = 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_done <= 1'b1;
            stub_cnt  <= 0;
        end else if (core_start) begin
            if (stub_starts >= ign_upto) begin
                core_done <= 1'b0;
                stub_cnt  <= job_lat - 1;
            end
            stub_starts <= stub_starts + 1;
        end else if (!core_done) begin
            if (stub_cnt == 0) core_done <= 1'b1;
            else               stub_cnt  <= stub_cnt - 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int rem [N];
    int last_served = N - 1;
    int exp_retry   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int l);
        for (int k = 1; k <= N; k++) begin
            if (m[(l + k) % N]) return (l + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < N; i++) req[i] = (rem[i] > 0);
    endtask

    task automatic do_job(input int lat, input bit ign, input logic [N-1:0] arrive);
        int          want_idx;
        int          cyc;
        int          nst;
        int          t_first;
        int          t_second;
        logic [N-1:0] eg;
        logic [15:0] em;
        logic [15:0] eo;
        want_idx = rr_pick(req, last_served);
        eg       = (want_idx >= 0) ? (N'(1) << want_idx) : '0;
        if (want_idx < 0) want_idx = 0;
        em       = maddr[want_idx*16 +: 16];
        eo       = oaddr[want_idx*16 +: 16];
        job_lat  = lat;
        ign_upto = stub_starts + int'(ign);

        cyc = 0;
        while (grant == '0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("msg_addr", 32'(core_message_addr), 32'(em));
        chk("out_addr", 32'(core_output_addr), 32'(eo));
        chk("busy_on", 32'(busy), 32'd1);

        nst = 0; t_first = 0; t_second = 0; cyc = 0;
        while (ack == '0 && cyc < lat + 40) begin
            if (core_start) begin
                if (nst == 0) t_first = cyc;
                else          t_second = cyc;
                nst++;
            end
            if (cyc == 1) begin
                for (int i = 0; i < N; i++) begin
                    maddr[i*16 +: 16] = 16'($urandom);
                    oaddr[i*16 +: 16] = 16'($urandom);
                    rem[i] += int'(arrive[i]);
                end
                oaddr[want_idx*16 +: 16] = 16'h0200;
                drive_req();
            end
            @(negedge clk);
            cyc++;
        end
        exp_retry += int'(ign);
        chk("ack", 32'(ack), 32'(eg));
        chk("start_pulses", 32'(nst), 32'(1 + int'(ign)));
        chk("last_cycles", 32'(last_cycles), 32'(lat + 1));
        chk("msg_addr_hold", 32'(core_message_addr), 32'(em));
        chk("out_addr_hold", 32'(core_output_addr), 32'(eo));
        chk("grant_in_ack", 32'(grant), 32'(eg));
        chk("retry_count", 32'(retry_count), 32'(exp_retry));
        if (ign) chk("retry_gap", 32'(t_second - t_first), 32'(TO + 1));

        @(negedge clk);
        chk("ack_clear", 32'(ack), 32'd0);
        chk("grant_clear", 32'(grant), 32'd0);
        chk("busy_off", 32'(busy), 32'd0);
        rem[want_idx]--;
        last_served = want_idx;
        drive_req();
    endtask

    initial begin
        int guard;
        int want_idx;
        logic [N-1:0] arr;
        for (int i = 0; i < N; i++) rem[i] = 0;
        req     = '0;
        maddr   = '0;
        oaddr   = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_msg", 32'(core_message_addr), 32'd0);
        chk("rst_out", 32'(core_output_addr), 32'd0);
        chk("rst_cycles", 32'(last_cycles), 32'd0);
        chk("rst_retry", 32'(retry_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single requester with fixed addresses.
        maddr[15:0] = 16'h0000;
        oaddr[15:0] = 16'h0100;
        rem[0] = 1;
        drive_req();
        do_job(10, 1'b0, '0);

        // All four at once, fixed latency.
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive_req();
        repeat (4) do_job(10, 1'b0, '0);

        // Requester 1 held high; requester 3 arrives mid-job.
        rem[1] = 3;
        drive_req();
        do_job(5, 1'b0, 4'b1000);
        rem[3] += 1;
        guard = 0;
        while (req != '0 && guard < 20) begin
            do_job(int'($urandom_range(1, 8)), 1'b0, '0);
            guard++;
        end

        // Start ignored once by the core.
        rem[2] = 1;
        drive_req();
        do_job(3, 1'b1, '0);

        // Randomized rounds.
        repeat (20) begin
            for (int i = 0; i < N; i++) rem[i] = int'($urandom_range(0, 2));
            if (rem[0] + rem[1] + rem[2] + rem[3] == 0) rem[$urandom_range(0, N-1)] = 1;
            drive_req();
            guard = 0;
            while (req != '0 && guard < 40) begin
                arr = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 15)) : '0;
                do_job(int'($urandom_range(1, 12)), ($urandom_range(0, 3) == 0), arr);
                guard++;
            end
        end

        // Reset while the core is running.
        rem[2] = 1;
        drive_req();
        job_lat  = 30;
        ign_upto = stub_starts;
        want_idx = rr_pick(req, last_served);
        guard = 0;
        while (grant == '0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_grant", 32'(grant), 32'(N'(1) << want_idx));
        repeat (6) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_start", 32'(core_start), 32'd0);
        chk("arst_retry", 32'(retry_count), 32'd0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive_req();
        @(negedge clk);
        reset_n     = 1'b1;
        last_served = N - 1;
        exp_retry   = 0;
        @(negedge clk);
        rem[0] = 1;
        rem[2] = 1;
        drive_req();
        guard = 0;
        while (req != '0 && guard < 10) begin
            do_job(4, 1'b0, '0);
            guard++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
